// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with per-channel period, high time, enable and tick.
// Optional CLKDIV_PHASE_EN adds a phase_sync input that realigns all running channels to cnt=0.
module clock_div_multi #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 12,
  parameter int RST_DIV  = 1,
  parameter int RST_HIGH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH*CNT_W-1:0] high_val,
`ifdef CLKDIV_PHASE_EN
  input  logic                    phase_sync,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_t;

  logic sync_req;
`ifdef CLKDIV_PHASE_EN
  assign sync_req = phase_sync;
`else
  assign sync_req = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] act_div, act_div_next, act_high, act_high_next;
    logic [CNT_W-1:0] sh_div, sh_high, sh_div_eff, sh_high_eff;
    logic             pending, pending_eff, pending_next;
    logic             wrap, restart, apply;
    logic             out_q, out_next;

    // A load arriving on the same cycle as a boundary is applied at that boundary.
    always_comb begin
      sh_div_eff    = cfg_load[i] ? div_val[i*CNT_W +: CNT_W]  : sh_div;
      sh_high_eff   = cfg_load[i] ? high_val[i*CNT_W +: CNT_W] : sh_high;
      pending_eff   = cfg_load[i] | pending;
      wrap          = (state != IDLE) && (cnt == act_div);
      restart       = wrap || ((state != IDLE) && sync_req);
      apply         = (state == IDLE) || restart;
      act_div_next  = act_div;
      act_high_next = act_high;
      pending_next  = pending_eff;
      if (apply) begin
        pending_next = 1'b0;
        if (pending_eff) begin
          act_div_next  = sh_div_eff;
          act_high_next = sh_high_eff;
        end
      end

      state_next = state;
      cnt_next   = cnt;
      case (state)
        IDLE: begin
          cnt_next = '0;
          if (ch_en[i]) state_next = RUN;
        end
        RUN: begin
          cnt_next = restart ? '0 : cnt + 1'b1;
          if (!ch_en[i]) state_next = wrap ? IDLE : DRAIN;
        end
        DRAIN: begin
          cnt_next = restart ? '0 : cnt + 1'b1;
          if (ch_en[i])  state_next = RUN;
          else if (wrap) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
      if (state_next == IDLE) cnt_next = '0;

      out_next = (state_next != IDLE) && (cnt_next < act_high_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        cnt      <= '0;
        act_div  <= CNT_W'(RST_DIV);
        act_high <= CNT_W'(RST_HIGH);
        sh_div   <= CNT_W'(RST_DIV);
        sh_high  <= CNT_W'(RST_HIGH);
        pending  <= 1'b0;
        out_q    <= 1'b0;
      end else begin
        state    <= state_next;
        cnt      <= cnt_next;
        act_div  <= act_div_next;
        act_high <= act_high_next;
        sh_div   <= sh_div_eff;
        sh_high  <= sh_high_eff;
        pending  <= pending_next;
        out_q    <= out_next;
      end
    end

    assign clk_out[i] = out_q;
    assign tick[i]    = (state != IDLE) && (cnt == '0);
    assign busy[i]    = (state != IDLE);
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi; expected waveforms are hand-derived bit patterns (bit k = cycle k).
module tb_clock_div_multi;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 12;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       cfg_load;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH*CNT_W-1:0] high_val;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       busy;
`ifdef CLKDIV_PHASE_EN
  logic                    phase_sync;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_DIV(1), .RST_HIGH(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_en(ch_en),
    .cfg_load(cfg_load),
    .div_val(div_val),
    .high_val(high_val),
`ifdef CLKDIV_PHASE_EN
    .phase_sync(phase_sync),
`endif
    .clk_out(clk_out),
    .tick(tick),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int ch, input int dv, input int hv);
    div_val[ch*CNT_W +: CNT_W]  = CNT_W'(dv);
    high_val[ch*CNT_W +: CNT_W] = CNT_W'(hv);
    cfg_load[ch] = 1'b1;
  endtask

  task automatic run_pattern(input string tag, input int ch, input int n,
                             input logic [31:0] e_clk, input logic [31:0] e_tick,
                             input logic [31:0] e_busy);
    for (int k = 0; k < n; k++) begin
      step();
      cfg_load = '0;
      check_val($sformatf("%s clk c%0d", tag, k),  32'(clk_out[ch]), 32'(e_clk[k]));
      check_val($sformatf("%s tick c%0d", tag, k), 32'(tick[ch]),    32'(e_tick[k]));
      check_val($sformatf("%s busy c%0d", tag, k), 32'(busy[ch]),    32'(e_busy[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    ch_en    = '0;
    cfg_load = '0;
    div_val  = '0;
    high_val = '0;
`ifdef CLKDIV_PHASE_EN
    phase_sync = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_val("rst clk_out", 32'(clk_out), 32'd0);
    check_val("rst tick",    32'(tick),    32'd0);
    check_val("rst busy",    32'(busy),    32'd0);

    // div=3 high=2 loaded while idle, enabled on the same cycle
    load_cfg(0, 3, 2);
    ch_en[0] = 1'b1;
    run_pattern("t1", 0, 8, 32'b0011_0011, 32'b0001_0001, 32'hFF);
    run_pattern("t1b", 0, 2, 32'b11, 32'b01, 32'b11);

    // load div=7 high=4 at cnt=1: old period finishes first
    load_cfg(0, 7, 4);
    run_pattern("t3", 0, 10, 32'b00_0011_1100, 32'b00_0000_0100, 32'h3FF);

    // load div=5 high=3 coincident with a wrap, then drop enable at cnt=1
    load_cfg(0, 5, 3);
    run_pattern("t4a", 0, 2, 32'b11, 32'b01, 32'b11);
    ch_en[0] = 1'b0;
    run_pattern("t4drain", 0, 6, 32'b00_0001, 32'b0, 32'b00_1111);
    ch_en[0] = 1'b1;
    run_pattern("t4b", 0, 2, 32'b11, 32'b01, 32'b11);
    ch_en[0] = 1'b0;
    run_pattern("t4c", 0, 2, 32'b01, 32'b00, 32'b11);
    ch_en[0] = 1'b1;
    run_pattern("t4reen", 0, 8, 32'b0001_1100, 32'b0000_0100, 32'hFF);
    run_pattern("t5pre", 0, 1, 32'b1, 32'b1, 32'b1);

    // async reset in the high phase
    rst_n = 1'b0;
    #1;
    check_val("t5 async clk_out", 32'(clk_out), 32'd0);
    check_val("t5 async tick",    32'(tick),    32'd0);
    check_val("t5 async busy",    32'(busy),    32'd0);
    #2;
    rst_n = 1'b1;
    run_pattern("t5rstcfg", 0, 4, 32'b0101, 32'b0101, 32'hF);

    // ch1: high=0, high>div, div=0 boundaries
    load_cfg(1, 4, 0);
    ch_en[1] = 1'b1;
    run_pattern("t2low", 1, 10, 32'd0, 32'b00001_00001, 32'h3FF);
    load_cfg(1, 4, 9);
    run_pattern("t2high", 1, 10, 32'h3FF, 32'b00001_00001, 32'h3FF);
    load_cfg(1, 0, 1);
    run_pattern("t2div0", 1, 4, 32'hF, 32'hF, 32'hF);
    load_cfg(1, 0, 0);
    run_pattern("t2div0low", 1, 3, 32'd0, 32'h7, 32'h7);

`ifdef CLKDIV_PHASE_EN
    load_cfg(0, 3, 2);
    load_cfg(1, 7, 4);
    step();
    cfg_load = '0;
    repeat (12) step();
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    check_val("t6 sync tick",    32'(tick),    32'b11);
    check_val("t6 sync clk_out", 32'(clk_out), 32'b11);
    repeat (8) step();
    check_val("t6 p8 tick",    32'(tick),    32'b11);
    check_val("t6 p8 clk_out", 32'(clk_out), 32'b11);
    repeat (2) step();
    check_val("t6 p8+2 clk_out", 32'(clk_out), 32'b10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
